// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the dual-requester APB master.
//   apb_state_t : bus phase sequencer states
//   apb_req_t   : a captured request {write, addr, wdata}
//   SLV_SEL_BIT : address bit that picks slave 2 (1) over slave 1 (0)
package apb_ctrl_pkg;

   localparam int DEF_ADDR_W  = 9;
   localparam int DEF_DATA_W  = 8;
   localparam int SLV_SEL_BIT = DEF_ADDR_W - 1;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_t;

   typedef struct packed {
      logic                  write;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] wdata;
   } apb_req_t;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst   : clock, synchronous active-high reset
//   valid[1:0] : pending requests
//   advance    : high when the bus can take a new transfer this cycle
//   grant[1:0] : one-hot winner, only while advance is high
// On a tie the requester that did not win last is granted; after reset the
// history says "1 won last" so requester 0 takes the first tie.
module apb_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_grant;

   always_comb begin
      grant = 2'b00;
      if (advance) begin
         case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         last_grant <= 1'b1;
      else if (|grant)
         last_grant <= grant[1];
   end

endmodule

// File: rtl/apb_dual_req_master.sv
// APB master shared by two requesters, driving two slaves.
//   PCLK, PRESET          : clock, synchronous active-high reset
//   reqN_valid/write/addr/wdata, reqN_ready : request handshake (ready is a
//                           combinational accept pulse)
//   rspN_valid/rdata/err  : one-cycle response to the owner of a transfer
//   PSEL1/PSEL2/PENABLE/PADDR/PWRITE/PWDATA : APB request side
//   PREADY/PRDATA/PSLVERR : APB completion side
// A transfer is SETUP then one or more ACCESS cycles. A new grant is taken
// in IDLE or in the ACCESS cycle that completes, so back-to-back transfers
// run with no idle gap. ACCESS is cut off with an error after TIMEOUT cycles
// without PREADY. The request latch uses apb_req_t, so ADDR_W/DATA_W must
// stay at the package defaults.
module apb_dual_req_master
   import apb_ctrl_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp0_err,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              rsp1_err,
   output logic              PSEL1,
   output logic              PSEL2,
   output logic              PENABLE,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PWRITE,
   output logic [DATA_W-1:0] PWDATA,
   input  logic              PREADY,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PSLVERR
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   apb_state_t        state, state_nxt;
   apb_req_t          lat, win_req;
   logic              lat_owner;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        grant;
   logic              advance, done;
   logic              rsp_vld, rsp_owner, rsp_err;
   logic [DATA_W-1:0] rsp_rdata;

   apb_rr_arb2 u_arb (
      .clk     (PCLK),
      .rst     (PRESET),
      .valid   ({req1_valid, req0_valid}),
      .advance (advance),
      .grant   (grant)
   );

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   always_comb begin
      done      = (state == ACCESS) && (PREADY || cnt == CNT_W'(TIMEOUT - 1));
      advance   = (state == IDLE) || done;
      win_req   = grant[1] ? {req1_write, req1_addr, req1_wdata}
                           : {req0_write, req0_addr, req0_wdata};
      state_nxt = state;
      case (state)
         IDLE:    if (|grant) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (done) state_nxt = (|grant) ? SETUP : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         lat       <= '0;
         lat_owner <= 1'b0;
         cnt       <= '0;
         rsp_vld   <= 1'b0;
         rsp_owner <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_vld <= done;
         // lat_owner is read before a same-cycle regrant overwrites it
         if (done) begin
            rsp_owner <= lat_owner;
            rsp_err   <= !PREADY || PSLVERR;
            rsp_rdata <= (PREADY && !PSLVERR && !lat.write) ? PRDATA : '0;
         end
         if (|grant) begin
            lat       <= win_req;
            lat_owner <= grant[1];
         end
         if (state_nxt == SETUP)  cnt <= '0;
         else if (state == ACCESS) cnt <= cnt + CNT_W'(1);
      end
   end

   // Bus phase is decoded from state; the address/data come straight from
   // the latch so they hold their last value while idle.
   always_comb begin
      PSEL1   = (state != IDLE) && !lat.addr[SLV_SEL_BIT];
      PSEL2   = (state != IDLE) &&  lat.addr[SLV_SEL_BIT];
      PENABLE = (state == ACCESS);
      PADDR   = lat.addr;
      PWRITE  = lat.write;
      PWDATA  = lat.wdata;
   end

   assign rsp0_valid = rsp_vld && !rsp_owner;
   assign rsp1_valid = rsp_vld &&  rsp_owner;
   assign rsp0_rdata = rsp0_valid ? rsp_rdata : '0;
   assign rsp1_rdata = rsp1_valid ? rsp_rdata : '0;
   assign rsp0_err   = rsp0_valid && rsp_err;
   assign rsp1_err   = rsp1_valid && rsp_err;

endmodule
